// File: rtl/rgmii_tx_framer.sv
// -----------------------------------------------------------------------------
// rgmii_tx_framer
//
// Transmit framing stage that sits in front of the RGMII DDR output stage.
// Takes a byte-wide AXI-Stream payload (destination MAC, source MAC, type,
// data) and produces GMII-style bytes: 7 preamble bytes, SFD, payload,
// optional zero padding, 4-byte CRC-32 FCS, then an enforced inter-frame gap.
//
// Build option:
//   RGMII_TX_PAD_EN - when defined, frames shorter than MIN_PAYLOAD are
//                     zero-padded up to MIN_PAYLOAD bytes before the FCS.
//                     When undefined, the pad path is absent and MIN_PAYLOAD
//                     has no effect.
//
// Parameters:
//   MIN_IFG      idle (tx_en=0) cycles enforced after the last FCS byte, 1..255
//   MIN_PAYLOAD  minimum bytes between SFD and FCS with padding, 1..255
//
// Ports:
//   clk            transmit byte clock, rising edge
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   payload byte
//   s_axis_tvalid  payload byte valid
//   s_axis_tready  framer accepts byte (decoded from state)
//   s_axis_tlast   last payload byte of the frame
//   s_axis_tuser   sampled with tlast; 1 forces a bad FCS
//   gmii_txd       transmit byte (registered)
//   gmii_tx_en     byte valid on line (registered)
//   gmii_tx_er     transmit error (registered)
//   busy           high whenever the framer is not idle (registered)
// -----------------------------------------------------------------------------
module rgmii_tx_framer #(
    parameter int MIN_IFG     = 12,
    parameter int MIN_PAYLOAD = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_DRAIN    = 3'd6,
        ST_IFG      = 3'd7
    } state_t;

    localparam logic [7:0]  IFG_LAST = 8'(MIN_IFG);
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
`ifdef RGMII_TX_PAD_EN
    localparam logic [7:0]  PAD_LEN  = 8'(MIN_PAYLOAD);
`endif

    // Reflected CRC-32 (poly 0xEDB88320), one byte folded in LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t      r_state;
    logic [7:0]  r_cnt;     // preamble / payload / FCS index / IFG counter
    logic [31:0] r_crc;
    logic        r_tuser;
    logic [7:0]  r_txd;
    logic        r_tx_en;
    logic        r_tx_er;
    logic        r_busy;

    state_t      w_state_nx;
    logic [7:0]  w_cnt_nx;
    logic [31:0] w_crc_nx;
    logic        w_tuser_nx;
    logic [7:0]  w_txd_nx;
    logic        w_tx_en_nx;
    logic        w_tx_er_nx;
    logic        w_sfd;
    logic [31:0] w_crc_base;
    logic [7:0]  w_cnt_base;
    logic [7:0]  w_cnt_inc;
    logic [31:0] w_fcs;

    // SFD restarts the CRC and payload count; first payload byte may arrive in SFD.
    assign w_sfd      = (r_state == ST_SFD);
    assign w_crc_base = w_sfd ? CRC_INIT : r_crc;
    assign w_cnt_base = w_sfd ? 8'd0 : r_cnt;
    assign w_cnt_inc  = (w_cnt_base == 8'hFF) ? 8'hFF : (w_cnt_base + 8'd1);
    // A flagged frame sends the CRC without final inversion, guaranteeing a bad FCS.
    assign w_fcs      = r_tuser ? r_crc : ~r_crc;

    assign s_axis_tready = (r_state == ST_SFD) || (r_state == ST_DATA) ||
                           (r_state == ST_DRAIN);
    assign gmii_txd      = r_txd;
    assign gmii_tx_en    = r_tx_en;
    assign gmii_tx_er    = r_tx_er;
    assign busy          = r_busy;

    // Next-state and next-line-byte decode; outputs describe the following cycle.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_crc_nx   = r_crc;
        w_tuser_nx = r_tuser;
        w_txd_nx   = 8'h00;
        w_tx_en_nx = 1'b0;
        w_tx_er_nx = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    w_state_nx = ST_PREAMBLE;
                    w_txd_nx   = 8'h55;
                    w_tx_en_nx = 1'b1;
                    w_cnt_nx   = 8'd1;
                end else begin
                    w_cnt_nx   = 8'd0;
                end
            end
            ST_PREAMBLE: begin
                w_tx_en_nx = 1'b1;
                if (r_cnt == 8'd7) begin
                    w_state_nx = ST_SFD;
                    w_txd_nx   = 8'hD5;
                    w_cnt_nx   = 8'd0;
                end else begin
                    w_txd_nx   = 8'h55;
                    w_cnt_nx   = r_cnt + 8'd1;
                end
            end
            ST_SFD, ST_DATA: begin
                w_crc_nx = w_crc_base;
                w_cnt_nx = w_cnt_base;
                if (s_axis_tvalid) begin
                    w_txd_nx   = s_axis_tdata;
                    w_tx_en_nx = 1'b1;
                    w_crc_nx   = crc32_byte(w_crc_base, s_axis_tdata);
                    w_cnt_nx   = w_cnt_inc;
                    w_state_nx = ST_DATA;
                    if (s_axis_tlast) begin
                        w_tuser_nx = s_axis_tuser;
`ifdef RGMII_TX_PAD_EN
                        if (w_cnt_inc < PAD_LEN) begin
                            w_state_nx = ST_PAD;
                        end else begin
                            w_state_nx = ST_FCS;
                            w_cnt_nx   = 8'd0;
                        end
`else
                        w_state_nx = ST_FCS;
                        w_cnt_nx   = 8'd0;
`endif
                    end else begin
                        w_tuser_nx = r_tuser;
                    end
                end else begin
                    // Underrun: one errored byte, then discard the rest of the frame.
                    w_txd_nx   = 8'h00;
                    w_tx_en_nx = 1'b1;
                    w_tx_er_nx = 1'b1;
                    if (s_axis_tlast) begin
                        w_state_nx = ST_IFG;
                    end else begin
                        w_state_nx = ST_DRAIN;
                    end
                    w_cnt_nx   = 8'd0;
                end
            end
`ifdef RGMII_TX_PAD_EN
            ST_PAD: begin
                w_txd_nx   = 8'h00;
                w_tx_en_nx = 1'b1;
                w_crc_nx   = crc32_byte(r_crc, 8'h00);
                if ((r_cnt + 8'd1) >= PAD_LEN) begin
                    w_state_nx = ST_FCS;
                    w_cnt_nx   = 8'd0;
                end else begin
                    w_cnt_nx   = r_cnt + 8'd1;
                end
            end
`endif
            ST_FCS: begin
                w_tx_en_nx = 1'b1;
                case (r_cnt[1:0])
                    2'd0:    w_txd_nx = w_fcs[7:0];
                    2'd1:    w_txd_nx = w_fcs[15:8];
                    2'd2:    w_txd_nx = w_fcs[23:16];
                    2'd3:    w_txd_nx = w_fcs[31:24];
                    default: w_txd_nx = 8'h00;
                endcase
                if (r_cnt == 8'd3) begin
                    w_state_nx = ST_IFG;
                    w_cnt_nx   = 8'd0;
                end else begin
                    w_cnt_nx   = r_cnt + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_state_nx = ST_IFG;
                    w_cnt_nx   = 8'd0;
                end else begin
                    w_state_nx = ST_DRAIN;
                end
            end
            ST_IFG: begin
                // Counts MIN_IFG+1 state cycles: MIN_IFG idle bytes plus the idle
                // cycle that leads into IDLE give the full gap before the preamble.
                if (r_cnt == IFG_LAST) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = 8'd0;
                end else begin
                    w_cnt_nx   = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = 8'd0;
            end
        endcase
    end

    // State, CRC and registered line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_crc   <= CRC_INIT;
            r_tuser <= 1'b0;
            r_txd   <= 8'h00;
            r_tx_en <= 1'b0;
            r_tx_er <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_crc   <= w_crc_nx;
            r_tuser <= w_tuser_nx;
            r_txd   <= w_txd_nx;
            r_tx_en <= w_tx_en_nx;
            r_tx_er <= w_tx_er_nx;
            r_busy  <= (w_state_nx != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for rgmii_tx_framer. Expected line bytes ({tx_er, txd})
// are pushed to a queue when a frame is offered and popped on every tx_en
// cycle. Frame length, inter-frame gap, tready during the gap and the CRC
// residue of the received bytes are checked after each frame.
// -----------------------------------------------------------------------------
module tb_rgmii_tx_framer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       s_axis_tlast;
    logic       s_axis_tuser;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       busy;

`ifdef RGMII_TX_PAD_EN
    localparam int PAD_MIN = 60;
`else
    localparam int PAD_MIN = 0;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  pl[$];
    logic [7:0]  rx[$];
    logic        hs = 1'b0;
    logic        prev_en = 1'b0;
    int          cur_len = 0;
    int          last_len = 0;
    int          low_run = 0;
    int          last_gap = 0;
    int          frames_done = 0;
    int          cyc = 0;
    logic        gap_rdy = 1'b0;
    logic        last_gap_rdy = 1'b0;
    logic [31:0] last_res = 32'h0;

    rgmii_tx_framer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .gmii_txd      (gmii_txd),
        .gmii_tx_en    (gmii_tx_en),
        .gmii_tx_er    (gmii_tx_er),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Bit-serial reflected CRC-32 reference.
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB8_8320;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [8:0]  e;
        logic [31:0] c;
        if (gmii_tx_en) begin
            if (!prev_en) begin
                if (frames_done > 0) begin
                    last_gap     = low_run;
                    last_gap_rdy = gap_rdy;
                end
                cur_len = 0;
                rx.delete();
            end
            cur_len++;
            rx.push_back(gmii_txd);
            if (exp_q.size() == 0) begin
                chk("unexpected_tx_en", 32'(gmii_tx_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("line_byte", 32'({gmii_tx_er, gmii_txd}), 32'(e));
            end
        end else begin
            if (prev_en) begin
                frames_done++;
                last_len = cur_len;
                c = 32'hFFFF_FFFF;
                for (int j = 8; j < rx.size(); j++) c = crc_upd(c, rx[j]);
                last_res = c;
                low_run  = 0;
                gap_rdy  = 1'b0;
            end
            low_run++;
            gap_rdy = gap_rdy | s_axis_tready;
        end
        prev_en = gmii_tx_en;
    endtask

    task automatic tick();
        @(negedge clk);
        hs = s_axis_tvalid && s_axis_tready;
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic push_prefix();
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
    endtask

    task automatic push_frame(input logic tu);
        logic [31:0] c;
        logic [31:0] f;
        int          npad;
        push_prefix();
        c = 32'hFFFF_FFFF;
        foreach (pl[i]) begin
            exp_q.push_back({1'b0, pl[i]});
            c = crc_upd(c, pl[i]);
        end
        npad = (pl.size() < PAD_MIN) ? (PAD_MIN - pl.size()) : 0;
        for (int i = 0; i < npad; i++) begin
            exp_q.push_back({1'b0, 8'h00});
            c = crc_upd(c, 8'h00);
        end
        f = tu ? c : ~c;
        exp_q.push_back({1'b0, f[7:0]});
        exp_q.push_back({1'b0, f[15:8]});
        exp_q.push_back({1'b0, f[23:16]});
        exp_q.push_back({1'b0, f[31:24]});
    endtask

    task automatic drive(input int first, input int last_excl, input logic tu);
        for (int i = first; i < last_excl; i++) begin
            int n;
            s_axis_tdata  = pl[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == pl.size() - 1);
            s_axis_tuser  = (i == pl.size() - 1) ? tu : 1'b0;
            n  = 0;
            hs = 1'b0;
            while (!hs && n < 200) begin
                tick();
                n++;
            end
            if (!hs) begin
                chk("handshake_wait", 32'(hs), 32'd1);
                break;
            end
        end
    endtask

    task automatic quiet();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tdata  = 8'h00;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        tick();
        while ((busy || gmii_tx_en || exp_q.size() != 0) && n < 600) begin
            tick();
            n++;
        end
        chk({tag, "_done_in_time"}, 32'(n < 600), 32'd1);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic fill_random(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int f0;
        int c0;
        rst_n = 1'b0;
        quiet();
        tick();
        tick();
        // Reset state
        chk("rst_txd",   32'(gmii_txd),      32'h00);
        chk("rst_tx_en", 32'(gmii_tx_en),    32'd0);
        chk("rst_tx_er", 32'(gmii_tx_er),    32'd0);
        chk("rst_tready",32'(s_axis_tready), 32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // 64-byte incrementing payload
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(i));
        push_frame(1'b0);
        drive(0, 64, 1'b0);
        quiet();
        wait_done("inc64");
        chk("inc64_len", 32'(last_len), 32'd76);
        chk("inc64_residue", last_res, 32'hDEBB_20E3);

`ifdef RGMII_TX_PAD_EN
        // 10-byte payload, padded to 60
        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'(i * 7 + 3));
        push_frame(1'b0);
        drive(0, 10, 1'b0);
        quiet();
        wait_done("pad10");
        chk("pad10_len", 32'(last_len), 32'd72);
        chk("pad10_residue", last_res, 32'hDEBB_20E3);
`else
        // "123456789" unpadded: known CRC-32 check value 0xCBF43926
        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
        push_frame(1'b0);
        drive(0, 9, 1'b0);
        quiet();
        wait_done("check9");
        chk("check9_len", 32'(last_len), 32'd21);
        chk("check9_fcs0", 32'(rx[17]), 32'h26);
        chk("check9_fcs1", 32'(rx[18]), 32'h39);
        chk("check9_fcs2", 32'(rx[19]), 32'hF4);
        chk("check9_fcs3", 32'(rx[20]), 32'hCB);
`endif

        // Two 60-byte frames back to back
        f0 = frames_done;
        fill_random(60);
        push_frame(1'b0);
        drive(0, 60, 1'b0);
        fill_random(60);
        push_frame(1'b0);
        drive(0, 60, 1'b0);
        quiet();
        wait_done("b2b");
        chk("b2b_frames", 32'(frames_done - f0), 32'd2);
        chk("b2b_gap", 32'(last_gap), 32'd13);
        chk("b2b_gap_tready", 32'(last_gap_rdy), 32'd0);
        chk("b2b_len", 32'(last_len), 32'd72);
        chk("b2b_residue", last_res, 32'hDEBB_20E3);

        // Upstream error flagged with tlast: complemented FCS, no tx_er
        fill_random(60);
        push_frame(1'b1);
        drive(0, 60, 1'b1);
        quiet();
        wait_done("tuser");
        chk("tuser_len", 32'(last_len), 32'd72);
        chk("tuser_residue_bad", 32'(last_res != 32'hDEBB_20E3), 32'd1);

        // Underrun after 20 bytes of a 64-byte frame
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(8'hA0 ^ i));
        push_prefix();
        for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, pl[i]});
        exp_q.push_back({1'b1, 8'h00});
        drive(0, 20, 1'b0);
        quiet();
        tick();
        c0 = cyc;
        drive(20, 64, 1'b0);
        chk("drain_cycles", 32'(cyc - c0), 32'd44);
        quiet();
        wait_done("underrun");
        chk("underrun_len", 32'(last_len), 32'd29);

        // Asynchronous reset during payload byte 30
        fill_random(64);
        push_frame(1'b0);
        drive(0, 30, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_en", 32'(gmii_tx_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_tready", 32'(s_axis_tready), 32'd0);
        exp_q.delete();
        prev_en = 1'b0;
        quiet();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        fill_random(12);
        push_frame(1'b0);
        drive(0, 12, 1'b0);
        quiet();
        wait_done("after_rst");
        chk("after_rst_len", 32'(last_len), 32'(8 + ((PAD_MIN > 12) ? PAD_MIN : 12) + 4));
        chk("after_rst_residue", last_res, 32'hDEBB_20E3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
